// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus bundle for apb_master_bridge.
// master = bridge side, slave = requester plus APB peripheral side.
interface apb_master_bridge_if;
    logic        i_CMD_VALID;
    logic        o_CMD_READY;
    logic        i_CMD_WRITE;
    logic [15:0] i_CMD_ADDR;
    logic [7:0]  i_CMD_WDATA;
    logic        o_RSP_VALID;
    logic [7:0]  o_RSP_RDATA;
    logic        o_RSP_TIMEOUT;
    logic        o_BUSY;
    logic        o_PSEL0;
    logic        o_PENABLE;
    logic        o_PWRITE;
    logic [15:0] o_PADDR;
    logic [7:0]  o_PWDATA;
    logic        i_PREADY;
    logic [7:0]  i_PRDATA;

    modport master (
        input  i_CMD_VALID, i_CMD_WRITE, i_CMD_ADDR, i_CMD_WDATA, i_PREADY, i_PRDATA,
        output o_CMD_READY, o_RSP_VALID, o_RSP_RDATA, o_RSP_TIMEOUT, o_BUSY,
        output o_PSEL0, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
    );

    modport slave (
        output i_CMD_VALID, i_CMD_WRITE, i_CMD_ADDR, i_CMD_WDATA, i_PREADY, i_PRDATA,
        input  o_CMD_READY, o_RSP_VALID, o_RSP_RDATA, o_RSP_TIMEOUT, o_BUSY,
        input  o_PSEL0, o_PENABLE, o_PWRITE, o_PADDR, o_PWDATA
    );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB initiator: valid/ready command in, SETUP/ACCESS transfer out,
// one-cycle response pulse back, with a wait-state watchdog. All outputs registered.
module apb_master_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned TCNT_W         = 8
) (
    input  logic                 i_PCLK,
    input  logic                 i_PRESET,
    apb_master_bridge_if.master  bus
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    localparam bit                TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [TCNT_W-1:0] TLast     = TCNT_W'(TimeoutEn ? TIMEOUT_CYCLES - 1 : 0);

    state_e            state_q, state_d;
    logic [TCNT_W-1:0] cnt_q, cnt_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [15:0]       paddr_q, paddr_d;
    logic [7:0]        pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_rdata_q, rsp_rdata_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_timeout_d = rsp_timeout_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_CMD_VALID && cmd_ready_q) begin
                    pwrite_d = bus.i_CMD_WRITE;
                    paddr_d  = bus.i_CMD_ADDR;
                    pwdata_d = bus.i_CMD_WRITE ? bus.i_CMD_WDATA : 8'h00;
                    cnt_d    = '0;
                    state_d  = StSetup;
                end
            end
            StSetup: state_d = StAccess;
            StAccess: begin
                // PREADY wins over the watchdog when both land on the same edge
                if (bus.i_PREADY) begin
                    rsp_rdata_d   = pwrite_q ? 8'h00 : bus.i_PRDATA;
                    rsp_timeout_d = 1'b0;
                    state_d       = StResp;
                end else if (TimeoutEn && (cnt_q == TLast)) begin
                    rsp_rdata_d   = 8'h00;
                    rsp_timeout_d = 1'b1;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + TCNT_W'(1);
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Control outputs are a pure function of the next state, so they register cleanly
        cmd_ready_d = (state_d == StIdle);
        busy_d      = (state_d != StIdle);
        psel_d      = (state_d == StSetup) || (state_d == StAccess);
        penable_d   = (state_d == StAccess);
        rsp_valid_d = (state_d == StResp);
    end

    always_ff @(posedge i_PCLK) begin
        if (i_PRESET) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b1;
            busy_q        <= 1'b0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= 16'h0000;
            pwdata_q      <= 8'h00;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= 8'h00;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            busy_q        <= busy_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.o_CMD_READY   = cmd_ready_q;
    assign bus.o_BUSY        = busy_q;
    assign bus.o_PSEL0       = psel_q;
    assign bus.o_PENABLE     = penable_q;
    assign bus.o_PWRITE      = pwrite_q;
    assign bus.o_PADDR       = paddr_q;
    assign bus.o_PWDATA      = pwdata_q;
    assign bus.o_RSP_VALID   = rsp_valid_q;
    assign bus.o_RSP_RDATA   = rsp_rdata_q;
    assign bus.o_RSP_TIMEOUT = rsp_timeout_q;

endmodule
